// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, default parameters and the 4x4 key map.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam int DEF_SCAN_DIV = 10000;
  localparam int DEF_DEBOUNCE_SCANS = 4;
  // Entry {row,col} sits at bits [{row,col}*4 +: 4]; row 0 col 0 ("1") is the LSB nibble.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer, reset value INIT.
// Ports: clk, rst (sync active-low), d (async in), q (synchronized out).
module sync2 #(
  parameter int W = 4,
  parameter logic [W-1:0] INIT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk)
    if (!rst) {q, m} <= {INIT, INIT};
    else {q, m} <= {m, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with debounce, emits hex key code.
// Ports: clk, rst (sync active-low), col_in (async active-low columns),
// row_out (one-hot-low row drive), key_code, key_valid (key held), key_pulse (press strobe).
module keypad_scanner import keypad_pkg::*; #(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pulse
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int TW = $clog2(DEBOUNCE_SCANS + 1);
  logic [3:0] col_s;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tally, tally_n;
  logic [1:0] row, row_n, lcol, lcol_n, c;
  state_t state, state_n;
  logic sample, any, load, valid_n;
  sync2 #(.W(4)) u_sync (.clk(clk), .rst(rst), .d(col_in), .q(col_s));
  // Sample point and wrap coincide, so a row change always lands right after a sample.
  assign sample = cnt == CW'(SCAN_DIV - 1);
  assign any = ~&col_s;
  assign c = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
  always_comb begin
    state_n = state;
    tally_n = tally;
    row_n = row;
    lcol_n = lcol;
    load = 1'b0;
    valid_n = key_valid;
    if (sample)
      case (state)
        SCAN:
          if (any) begin
            lcol_n = c;
            tally_n = TW'(1);
            load = DEBOUNCE_SCANS == 1;
            state_n = load ? PRESSED : DEBOUNCE;
          end else row_n = row + 2'd1;
        DEBOUNCE:
          if (!col_s[lcol]) begin
            tally_n = tally + TW'(1);
            load = int'(tally) + 1 == DEBOUNCE_SCANS;
            state_n = load ? PRESSED : DEBOUNCE;
          end else begin
            state_n = SCAN;
            row_n = row + 2'd1;
          end
        PRESSED:
          if (col_s[lcol]) begin
            tally_n = TW'(1);
            state_n = DEBOUNCE_SCANS == 1 ? SCAN : RELEASE;
            valid_n = DEBOUNCE_SCANS != 1;
            row_n = DEBOUNCE_SCANS == 1 ? row + 2'd1 : row;
          end
        RELEASE:
          if (col_s[lcol]) begin
            tally_n = tally + TW'(1);
            if (int'(tally) + 1 == DEBOUNCE_SCANS) begin
              state_n = SCAN;
              valid_n = 1'b0;
              row_n = row + 2'd1;
            end
          end else state_n = PRESSED;
      endcase
    valid_n = load | valid_n;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= SCAN;
      cnt <= '0;
      tally <= '0;
      row <= '0;
      lcol <= '0;
      row_out <= 4'b1110;
      key_code <= '0;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= sample ? '0 : cnt + CW'(1);
      tally <= tally_n;
      row <= row_n;
      lcol <= lcol_n;
      row_out <= ~(4'b0001 << row_n);
      key_code <= load ? key_of(row, lcol_n) : key_code;
      key_valid <= valid_n;
      key_pulse <= load;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model plus press scoreboard for keypad_scanner.
module tb_keypad_scanner;
  logic clk = 0, rst = 0;
  logic [3:0] col_in, row_out, key_code;
  logic key_valid, key_pulse, prev_pulse = 0;
  logic [15:0] keys = '0;
  logic [3:0] exp_q[$];
  int tests = 0, fails = 0, n;
  logic [3:0] rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_valid(key_valid), .key_pulse(key_pulse));

  always #5 clk = ~clk;

  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_pulse) begin
      chk("pulse_width", int'(prev_pulse), 0);
      chk("pulse_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("key_code", int'(key_code), int'(exp_q.pop_front()));
    end
    prev_pulse <= key_pulse;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input logic lvl, input int budget, output int cnt);
    cnt = 0;
    while (key_valid !== lvl && cnt < budget) begin
      tick(1);
      cnt++;
    end
    chk(tag, int'(key_valid), int'(lvl));
  endtask

  task automatic wait_row(input logic [3:0] exp, input int budget);
    int k = 0;
    while (row_out !== exp && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_row", int'(row_out), int'(exp));
  endtask

  initial begin
    tick(5);
    chk("rst_row", int'(row_out), 4'b1110);
    chk("rst_code", int'(key_code), 0);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_pulse", int'(key_pulse), 0);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick(4);
      chk("idle_row", int'(row_out), int'(rows[i]));
    end
    keys[1*4+2] = 1;
    exp_q.push_back(4'h6);
    wait_valid("press6", 1, 64, n);
    chk("press6_lat", n, 16);
    chk("press6_pulse", int'(key_pulse), 1);
    chk("press6_code", int'(key_code), 6);
    chk("press6_row", int'(row_out), 4'b1101);
    keys = '0;
    wait_valid("rel6", 0, 64, n);
    chk("rel6_lat", n, 12);
    chk("rel6_row", int'(row_out), 4'b1011);
    wait_row(4'b1110, 64);
    keys[0*4+3] = 1;
    tick(4);
    chk("bounce_frozen", int'(row_out), 4'b1110);
    keys = '0;
    tick(4);
    chk("bounce_row", int'(row_out), 4'b1101);
    chk("bounce_valid", int'(key_valid), 0);
    wait_row(4'b0111, 64);
    keys[3*4+2] = 1;
    exp_q.push_back(4'hF);
    wait_valid("pressF", 1, 64, n);
    chk("pressF_code", int'(key_code), 15);
    keys = '0;
    tick(4);
    keys[3*4+2] = 1;
    tick(4);
    chk("glitch_valid", int'(key_valid), 1);
    tick(4);
    chk("glitch_code", int'(key_code), 15);
    keys = '0;
    wait_valid("relF", 0, 64, n);
    chk("relF_lat", n, 12);
    chk("relF_row", int'(row_out), 4'b1110);
    tick(4);
    chk("resume_row", int'(row_out), 4'b1101);
    wait_row(4'b1110, 64);
    keys[2*4+1] = 1;
    keys[2*4+3] = 1;
    exp_q.push_back(4'h8);
    wait_valid("prio", 1, 64, n);
    chk("prio_code", int'(key_code), 8);
    keys[0] = 1;
    tick(20);
    chk("lock_code", int'(key_code), 8);
    chk("lock_valid", int'(key_valid), 1);
    chk("lock_row", int'(row_out), 4'b1011);
    keys = '0;
    wait_valid("prio_rel", 0, 64, n);
    wait_row(4'b1101, 64);
    keys[1*4+1] = 1;
    tick(4);
    chk("deb_frozen", int'(row_out), 4'b1101);
    rst = 0;
    tick(1);
    chk("rdeb_valid", int'(key_valid), 0);
    chk("rdeb_row", int'(row_out), 4'b1110);
    chk("rdeb_pulse", int'(key_pulse), 0);
    keys = '0;
    tick(1);
    rst = 1;
    wait_row(4'b1101, 64);
    keys[1*4+1] = 1;
    exp_q.push_back(4'h5);
    wait_valid("press5", 1, 64, n);
    rst = 0;
    tick(1);
    chk("rprs_valid", int'(key_valid), 0);
    chk("rprs_row", int'(row_out), 4'b1110);
    chk("rprs_pulse", int'(key_pulse), 0);
    chk("rprs_code", int'(key_code), 0);
    keys = '0;
    tick(1);
    rst = 1;
    tick(40);
    chk("idle_valid", int'(key_valid), 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 passive matrix keypad, synchronizes and debounces the column inputs, and outputs a 4-bit hex key code with a data-available flag. It sits directly upstream of `ModuloTeclado` in the 10 MHz domain and replaces an external encoder IC:
- `key_code[3:0]` drives inputs A (bit 3), B, C and D (bit 0).
- `key_valid` drives input E.

## Interface
Parameters:
- `SCAN_DIV`, 10000, clock cycles per row slot (1 ms at 10 MHz); minimum 4.
- `DEBOUNCE_SCANS`, 4, number of consecutive matching slot samples needed to accept a press or a release; minimum 1.

Ports:
- `clk`  in  1  system clock, 10 MHz (`CLK_10MHz`).
- `rst`  in  1  reset; synchronous, active-low.
- `col_in`  in  4  keypad columns; active-low, externally pulled up, asynchronous.
- `row_out`  out  4  row drive; active-low, one-hot-low.
- `key_code`  out  4  code of the accepted key; held until the next accepted press.
- `key_valid`  out  1  high while a debounced key is held.
- `key_pulse`  out  1  one-cycle strobe when a press is accepted.

## Operation
- **Column synchronizer:** two flip-flop stages on `col_in`. All decisions use the synchronized value `col_s`.
- **Slot counter:** counts 0..SCAN_DIV-1 and wraps.
  - The sample point is count SCAN_DIV-1.
  - The row changes only at the wrap.
- **Column selection:** when more than one column is low, the lowest column index wins. Only one key is tracked at a time.
- **FSM states:**
  - **SCAN:** rows rotate 0→1→2→3→0. At the sample point, if any `col_s` bit is low:
    - latch the row and column;
    - set hit count to 1;
    - go to DEBOUNCE. The row stays frozen from here on.
    - If DEBOUNCE_SCANS=1, go directly to PRESSED instead.
  - **DEBOUNCE:** at each sample point:
    - If the latched column is still low, increment the hit count. When it reaches DEBOUNCE_SCANS, go to PRESSED.
    - Otherwise return to SCAN and advance to the next row at the wrap.
  - **PRESSED:** on entry:
    - `key_code` is loaded from the map;
    - `key_valid` goes to 1;
    - `key_pulse` goes to 1 for exactly one cycle.
    - Then, at each sample point, a high latched column means go to RELEASE with miss count 1.
  - **RELEASE:** at each sample point:
    - A high latched column increments the miss count. At DEBOUNCE_SCANS, go to SCAN with `key_valid` set to 0 and the row advancing at the next wrap.
    - A low latched column returns to PRESSED with no new `key_pulse` and no `key_code` reload.
- **Key map** (row r, column c):
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: `*`=E, 0, `#`=F, D
- **Simultaneous keys:**
  - A second key pressed while a key is held is ignored.
  - Keys in other rows are invisible while the row is frozen.

## Timing
- **Reset values:**
  - `row_out` = 4'b1110 (row 0);
  - `key_code` = 0, `key_valid` = 0, `key_pulse` = 0;
  - FSM = SCAN; slot, hit and miss counters = 0; synchronizer = 4'b1111.
- **Reset mid-operation:** reset in any state returns all of the above on the next edge. No pulse is emitted.
- **Input latency:** 2 cycles from `col_in` to `col_s`. Sampling at the end of the slot guarantees at least SCAN_DIV-3 settle cycles after a row change.
- **Press latency:** `key_valid` and `key_pulse` rise in the cycle after the sample point on which the hit count reaches DEBOUNCE_SCANS. From the first detecting sample this is (DEBOUNCE_SCANS-1)·SCAN_DIV + 1 cycles.
- **Release latency:** `key_valid` falls (DEBOUNCE_SCANS-1)·SCAN_DIV + 1 cycles after the first high sample.
- **Output registration:** all outputs are registered. `key_code` changes in the same cycle that `key_pulse` rises, and is stable while `key_valid` is high.

## Structure
- **Package `keypad_pkg`** holds:
  - the FSM state enum (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - the 16-entry key map constant;
  - default parameter constants.
- **Sub-module `sync2`:** a 2-flip-flop synchronizer, parameterized on width, instantiated here with width 4.
- **Remaining logic:** the counters and FSM live in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3 unless stated.
- **Reset and idle:** hold `rst`=0 for 5 cycles with all columns high.
  - Outputs must be 1110/0/0/0.
  - After release, `row_out` must cycle 1110→1101→1011→0111 every 4 cycles.
- **Clean press:** the model closes key "6" (row 1, column 2).
  - The row freezes at 1101.
  - After 3 samples, `key_code`=6, `key_valid`=1 and `key_pulse` is exactly 1 cycle.
- **Bounce rejection:** key "A" is low for 1 sample, then high.
  - No `key_pulse` occurs.
  - FSM returns to SCAN and the row advances to 1101.
- **Release and glitch:** while "#" is held (`key_code`=F):
  - 1 high sample then low again: `key_valid` stays 1 and no new pulse occurs.
  - 3 high samples: `key_valid` goes to 0 and scanning resumes.
- **Priority and locking:**
  - Row 2 columns 1 and 3 both low gives `key_code`=8.
  - Then pressing "1" in row 0 while 8 is held produces no change.
- **Reset mid-operation:** assert `rst`=0 during DEBOUNCE and during PRESSED.
  - The next edge gives `key_valid`=0 and `row_out`=1110, and no pulse occurs.
